// File: rtl/ula_sequencer.sv
// ula_sequencer: request-side front end for the ULA arithmetic unit.
//
// One operation is accepted at a time over a valid/ready request channel.
// Its operands and opcode are registered and held stable on the ULA inputs.
// After ALU_LAT cycles the ULA result and zero flag are sampled, and the
// response is then returned over a valid/ready response channel. Illegal
// opcodes bypass the ULA and produce a flagged response after one cycle.
// Completed responses are counted in a wrapping 16-bit counter.
//
// Optional feature: define ULA_SEQ_FLAGS_EN to register a sign flag
// (rsp_neg_o = result MSB). Without it, rsp_neg_o is tied low.
//
// Parameters:
//   DATA_W  - operand/result width
//   OP_W    - opcode width
//   ALU_LAT - cycles from accept to result sample (1..15)
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   req_valid_i/ready_o    - request handshake
//   req_opcode_i, req_a_i, req_b_i - request payload
//   ula_a_o, ula_b_o, ula_opcode_o - registered ULA inputs
//   ula_out_i, ula_zero_i  - ULA result and zero/compare flag
//   rsp_valid_o/ready_i    - response handshake
//   rsp_result_o, rsp_zero_o, rsp_illegal_o, rsp_neg_o - response payload
//   busy_o                 - high whenever not idle
//   op_count_o             - completed-response counter
module ula_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OP_W-1:0]   req_opcode_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  output logic [DATA_W-1:0] ula_a_o,
  output logic [DATA_W-1:0] ula_b_o,
  output logic [OP_W-1:0]   ula_opcode_o,
  input  logic [DATA_W-1:0] ula_out_i,
  input  logic              ula_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_illegal_o,
  output logic              rsp_neg_o,
  output logic              busy_o,
  output logic [15:0]       op_count_o
);

  localparam logic [OP_W-1:0] OpCompare = OP_W'(2);
  localparam logic [OP_W-1:0] OpZeros   = OP_W'(16);
  localparam logic [3:0]      LatCnt    = 4'(ALU_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   ula_a_q, ula_a_d;
  logic [DATA_W-1:0]   ula_b_q, ula_b_d;
  logic [OP_W-1:0]     ula_op_q, ula_op_d;
  // Marks the in-flight operation as illegal; ula_op_q still holds the
  // previous legal opcode in that case, so it cannot be decoded instead.
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                rsp_ill_q, rsp_ill_d;
  logic [15:0]         count_q, count_d;
  logic                sample;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op == OP_W'(7)) || ((op >= OP_W'(10)) && (op <= OP_W'(15)));
  endfunction

  // Result capture happens on the last EXEC cycle.
  assign sample = (state_q == StExec) && (cnt_q == 4'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ula_a_d   = ula_a_q;
    ula_b_d   = ula_b_q;
    ula_op_d  = ula_op_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    zero_d    = zero_q;
    rsp_ill_d = rsp_ill_q;
    count_d   = count_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StExec;
          if (is_illegal(req_opcode_i)) begin
            // The ULA inputs are left untouched so it never sees a bogus opcode.
            illegal_d = 1'b1;
            cnt_d     = 4'd1;
          end else begin
            illegal_d = 1'b0;
            cnt_d     = LatCnt;
            ula_a_d   = req_a_i;
            ula_b_d   = req_b_i;
            ula_op_d  = req_opcode_i;
          end
        end
      end

      StExec: begin
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          if (illegal_q) begin
            result_d  = '0;
            zero_d    = 1'b0;
            rsp_ill_d = 1'b1;
          end else if (ula_op_q == OpCompare) begin
            // Compare reports only the flag; the ULA's Out is not meaningful.
            result_d  = '0;
            zero_d    = ula_zero_i;
            rsp_ill_d = 1'b0;
          end else begin
            result_d  = ula_out_i;
            zero_d    = (ula_out_i == '0);
            rsp_ill_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          count_d = count_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ula_a_q   <= '0;
      ula_b_q   <= '0;
      ula_op_q  <= OpZeros;
      illegal_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      rsp_ill_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ula_a_q   <= ula_a_d;
      ula_b_q   <= ula_b_d;
      ula_op_q  <= ula_op_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      rsp_ill_q <= rsp_ill_d;
      count_q   <= count_d;
    end
  end

`ifdef ULA_SEQ_FLAGS_EN
  logic neg_q, neg_d;

  always_comb begin
    neg_d = neg_q;
    if (sample) begin
      neg_d = !illegal_q && (ula_op_q != OpCompare) && ula_out_i[DATA_W-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign rsp_neg_o = neg_q;
`else
  assign rsp_neg_o = 1'b0;
`endif

  assign req_ready_o   = (state_q == StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign busy_o        = (state_q != StIdle);
  assign ula_a_o       = ula_a_q;
  assign ula_b_o       = ula_b_q;
  assign ula_opcode_o  = ula_op_q;
  assign rsp_result_o  = result_q;
  assign rsp_zero_o    = zero_q;
  assign rsp_illegal_o = rsp_ill_q;
  assign op_count_o    = count_q;

endmodule
